// File: rtl/bcd_stopwatch_counter_pkg.sv
// Shared encodings for the reaction-timer stopwatch: game states and BCD digit limits.
package bcd_stopwatch_counter_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ARM  = 2'b01,
      ST_TIME = 2'b10,
      ST_CMP  = 2'b11
   } game_state_e;

endpackage

// File: rtl/bcd_stopwatch_counter_digit.sv
// One decade counter of the stopwatch cascade; carries out when incremented at 9.
module bcd_digit
   import bcd_stopwatch_counter_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               clr,
   input  logic               inc,
   input  logic               hold_max,
   output logic [DIGIT_W-1:0] q,
   output logic               co
);

   assign co = inc & (q == BCD_MAX);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && !hold_max) begin
         q <= (q == BCD_MAX) ? '0 : q + 1'b1;
      end
   end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Four-digit BCD stopwatch (0.000 to 9.999 s) advanced by a 1 ms prescaler tick while timing.
module bcd_stopwatch_counter
   import bcd_stopwatch_counter_pkg::*;
#(
   parameter int CLK_PER_MS = 50000,
   parameter int PRESC_W    = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] state,
   output logic [3:0] S,
   output logic [3:0] tS,
   output logic [3:0] hS,
   output logic [3:0] mS,
   output logic       Ovf,
   output logic       Tick
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_MS - 1);

   logic [PRESC_W-1:0] presc;
   logic               running;
   logic               arm;
   logic               tick_raw;
   logic               all_max;
   logic               co_ms;
   logic               co_hs;
   logic               co_ts;
   logic               co_s;

   assign running  = (state == ST_TIME);
   assign arm      = (state == ST_ARM);
   assign tick_raw = running && (presc == PRESC_LAST);
   assign all_max  = (S == BCD_MAX) && (tS == BCD_MAX) && (hS == BCD_MAX) && (mS == BCD_MAX);

   // Prescaler restarts whenever timing is not active so every run begins with a full period.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         presc <= '0;
      end else if (!running || tick_raw) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   bcd_digit u_ms (
      .Clk      (Clk),
      .Reset    (Reset),
      .clr      (arm),
      .inc      (tick_raw),
      .hold_max (all_max),
      .q        (mS),
      .co       (co_ms)
   );

   bcd_digit u_hs (
      .Clk      (Clk),
      .Reset    (Reset),
      .clr      (arm),
      .inc      (co_ms),
      .hold_max (all_max),
      .q        (hS),
      .co       (co_hs)
   );

   bcd_digit u_ts (
      .Clk      (Clk),
      .Reset    (Reset),
      .clr      (arm),
      .inc      (co_hs),
      .hold_max (all_max),
      .q        (tS),
      .co       (co_ts)
   );

   bcd_digit u_s (
      .Clk      (Clk),
      .Reset    (Reset),
      .clr      (arm),
      .inc      (co_ts),
      .hold_max (all_max),
      .q        (S),
      .co       (co_s)
   );

   // A carry out of the seconds digit means a tick landed on 9.999: saturate instead.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Tick <= 1'b0;
         Ovf  <= 1'b0;
      end else begin
         Tick <= tick_raw && !all_max;
         if (arm) begin
            Ovf <= 1'b0;
         end else if (co_s) begin
            Ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for the BCD stopwatch with a 4-cycle millisecond prescaler.
module tb_bcd_stopwatch_counter;

   localparam int CPM = 4;

   typedef struct {
      logic [1:0]  st;
      int          n;
      logic [15:0] dig;
      logic        ovf;
      logic        tick;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [1:0] state;
   logic [3:0] S, tS, hS, mS;
   logic       Ovf, Tick;
   logic [15:0] digits;

   int checks   = 0;
   int failures = 0;

   vec_t vecs [11];

   bcd_stopwatch_counter #(
      .CLK_PER_MS (CPM),
      .PRESC_W    (3)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .state (state),
      .S     (S),
      .tS    (tS),
      .hS    (hS),
      .mS    (mS),
      .Ovf   (Ovf),
      .Tick  (Tick)
   );

   always #5 Clk = ~Clk;

   assign digits = {S, tS, hS, mS};

   always @(negedge Clk) begin
      if (!Reset) begin
         checks++;
         if (S > 4'd9 || tS > 4'd9 || hS > 4'd9 || mS > 4'd9) begin
            failures++;
            $display("FAIL bcd_range: digits=%h required each digit <= 9", digits);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [15:0] ed, input logic eo, input logic et);
      chk({name, " digits"}, digits, ed);
      chk({name, " ovf"}, {15'd0, Ovf}, {15'd0, eo});
      chk({name, " tick"}, {15'd0, Tick}, {15'd0, et});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{2'b00, 1,  16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{2'b01, 3,  16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{2'b10, 3,  16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{2'b10, 1,  16'h0001, 1'b0, 1'b1};
      vecs[4]  = '{2'b10, 1,  16'h0001, 1'b0, 1'b0};
      vecs[5]  = '{2'b10, 35, 16'h0010, 1'b0, 1'b1};
      vecs[6]  = '{2'b10, 2,  16'h0010, 1'b0, 1'b0};
      vecs[7]  = '{2'b11, 20, 16'h0010, 1'b0, 1'b0};
      vecs[8]  = '{2'b00, 5,  16'h0010, 1'b0, 1'b0};
      vecs[9]  = '{2'b10, 4,  16'h0011, 1'b0, 1'b1};
      vecs[10] = '{2'b01, 1,  16'h0000, 1'b0, 1'b0};

      Reset = 1'b1;
      state = 2'b00;
      step(2);
      chk_all("reset", 16'h0000, 1'b0, 1'b0);
      Reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         state = vecs[i].st;
         step(vecs[i].n);
         chk_all($sformatf("vec%0d", i), vecs[i].dig, vecs[i].ovf, vecs[i].tick);
      end

      // Carry chain 0.999 -> 1.000 in one update
      state = 2'b10;
      step(999 * CPM);
      chk_all("at_0999", 16'h0999, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk_all("pre_carry", 16'h0999, 1'b0, 1'b0);
      end
      step(1);
      chk_all("carry_1000", 16'h1000, 1'b0, 1'b1);

      // Saturation at 9.999
      step(8999 * CPM);
      chk_all("at_9999", 16'h9999, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         step(1);
         chk_all($sformatf("sat%0d", i), 16'h9999, (i >= 4), 1'b0);
      end
      state = 2'b01;
      step(1);
      chk_all("arm_clears", 16'h0000, 1'b0, 1'b0);

      // Stop on the tick cycle at 0.537, hold, then resume
      state = 2'b10;
      step(537 * CPM);
      chk_all("at_0537", 16'h0537, 1'b0, 1'b1);
      step(CPM - 1);
      chk_all("tick_cycle", 16'h0537, 1'b0, 1'b0);
      state = 2'b11;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk_all("hold_cmp", 16'h0537, 1'b0, 1'b0);
      end
      state = 2'b00;
      step(3);
      chk_all("hold_idle", 16'h0537, 1'b0, 1'b0);
      state = 2'b10;
      step(CPM - 1);
      chk_all("resume_wait", 16'h0537, 1'b0, 1'b0);
      step(1);
      chk_all("resume_0538", 16'h0538, 1'b0, 1'b1);

      // Asynchronous reset mid-count at 0.123
      state = 2'b01;
      step(1);
      state = 2'b10;
      step(123 * CPM);
      chk_all("at_0123", 16'h0123, 1'b0, 1'b1);
      Reset = 1'b1;
      #2;
      chk_all("async_reset", 16'h0000, 1'b0, 1'b0);
      state = 2'b00;
      step(1);
      Reset = 1'b0;
      step(2);
      chk_all("post_reset_idle", 16'h0000, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
